rect_raster_engine: RTL and testbench

//  Parametrised successor of the 1-bit GPU: rasterises axis-aligned filled rectangles into the frame buffer.

---
 rtl/gpu2_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/rect_raster_engine.sv | 158 +++++++++++++++
 tb/tb_rect_raster_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gpu2_pkg.sv
// Shared types for the rectangle rasteriser: the op record, the FSM state and width helpers.
// The op fields are sized for frames of up to 1024x512 pixels. Smaller frames ignore the unused range.
package gpu2_pkg;
   localparam int OP_X_W = 10;
   localparam int OP_Y_W = 9;
   localparam int OP_C_W = 4;

   typedef struct packed {
      logic [OP_X_W-1:0] x;
      logic [OP_Y_W-1:0] y;
      logic [OP_X_W:0]   w;
      logic [OP_Y_W:0]   h;
      logic [OP_C_W-1:0] color;
   } rect_op_t;

   typedef enum logic [1:0] {IDLE, LOAD, DRAW, CLEAR} fsm_state_t;

   // Index width for n items. It never returns 0, so degenerate sizes still give a legal vector.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with clock enable and synchronous flush; the head is visible on dout while non-empty.
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (ce) begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ce && !flush && do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/rect_raster_engine.sv
// Rasterises clipped, axis-aligned filled rectangles into frame-buffer writes, one pixel per enabled cycle.
// A swap aborts the current work, flushes queued ops and can optionally start a full-frame background clear.
module rect_raster_engine
   import gpu2_pkg::*;
#(
   parameter int                     HOR_ACTIVE_PIXELS = 640,
   parameter int                     VER_ACTIVE_PIXELS = 480,
   parameter int                     COLOR_WIDTH       = 4,
   parameter int                     OP_FIFO_DEPTH     = 8,
   parameter bit                     CLEAR_ON_SWAP     = 1'b1,
   parameter logic [COLOR_WIDTH-1:0] BG_COLOR          = '0,
   localparam int                    ADDR_W            = idx_w(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic                   swap,
   input  rect_op_t               op,
   input  logic                   op_valid,
   output logic                   op_ready,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [COLOR_WIDTH-1:0] wr_data,
   output logic                   busy
);
   localparam int                X_W    = idx_w(HOR_ACTIVE_PIXELS);
   localparam int                Y_W    = idx_w(VER_ACTIVE_PIXELS);
   localparam int                SX_W   = OP_X_W + 2;
   localparam int                SY_W   = OP_Y_W + 2;
   localparam logic [SX_W-1:0]   HOR_SX = SX_W'(HOR_ACTIVE_PIXELS);
   localparam logic [SY_W-1:0]   VER_SY = SY_W'(VER_ACTIVE_PIXELS);
   localparam logic [ADDR_W-1:0] HOR_A  = ADDR_W'(HOR_ACTIVE_PIXELS);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS - 1);

   fsm_state_t        state;
   logic              rdy_en;
   logic              fifo_empty, fifo_full, push, pop;
   rect_op_t          head;
   logic [X_W-1:0]    x0, x_last, cur_x, x_c;
   logic [Y_W-1:0]    y_last, cur_y, y_c;
   logic [ADDR_W-1:0] row_base, row_base_c;
   logic [SX_W-1:0]   x_sum, x_end;
   logic [SY_W-1:0]   y_sum, y_end;
   logic              clip_empty;

   // Constant multiply by the frame width as a sum of shifted copies of y.
   function automatic logic [ADDR_W-1:0] mul_hor(input logic [Y_W-1:0] yv);
      logic [ADDR_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < ADDR_W; i++)
         if (HOR_A[i]) acc = acc + (ADDR_W'(yv) << i);
      return acc;
   endfunction

   assign push     = ce && op_valid && op_ready && !swap;
   assign pop      = ce && !swap && (state == LOAD);
   assign op_ready = rdy_en && !fifo_full && (state != CLEAR);
   assign busy     = !fifo_empty || (state != IDLE);

   sync_fifo #(.WIDTH($bits(rect_op_t)), .DEPTH(OP_FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .flush (ce && swap),
      .push  (push),
      .din   (op),
      .pop   (pop),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Clip the head op against the screen. The sums are two bits wider than the fields, so they never wrap.
   always_comb begin
      x_sum      = SX_W'(head.x) + SX_W'(head.w);
      y_sum      = SY_W'(head.y) + SY_W'(head.h);
      x_end      = (x_sum > HOR_SX) ? HOR_SX : x_sum;
      y_end      = (y_sum > VER_SY) ? VER_SY : y_sum;
      clip_empty = (SX_W'(head.x) >= HOR_SX) || (SY_W'(head.y) >= VER_SY) ||
                   (head.w == '0) || (head.h == '0);
      x_c        = X_W'(head.x);
      y_c        = Y_W'(head.y);
      row_base_c = mul_hor(y_c);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         rdy_en   <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         x0       <= '0;
         x_last   <= '0;
         cur_x    <= '0;
         y_last   <= '0;
         cur_y    <= '0;
         row_base <= '0;
      end else if (ce) begin
         rdy_en <= 1'b1;
         if (swap) begin
            if (CLEAR_ON_SWAP) begin
               state   <= CLEAR;
               wr_en   <= 1'b1;
               wr_addr <= '0;
               wr_data <= BG_COLOR;
            end else begin
               state <= IDLE;
               wr_en <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: if (!fifo_empty) state <= LOAD;
               LOAD: begin
                  if (clip_empty) begin
                     state <= IDLE;
                  end else begin
                     state    <= DRAW;
                     wr_en    <= 1'b1;
                     wr_addr  <= row_base_c + ADDR_W'(x_c);
                     wr_data  <= COLOR_WIDTH'(head.color);
                     x0       <= x_c;
                     cur_x    <= x_c;
                     x_last   <= X_W'(x_end - 1'b1);
                     cur_y    <= y_c;
                     y_last   <= Y_W'(y_end - 1'b1);
                     row_base <= row_base_c;
                  end
               end
               DRAW: begin
                  if (cur_x != x_last) begin
                     cur_x   <= cur_x + 1'b1;
                     wr_addr <= wr_addr + 1'b1;
                  end else if (cur_y != y_last) begin
                     cur_x    <= x0;
                     cur_y    <= cur_y + 1'b1;
                     row_base <= row_base + HOR_A;
                     wr_addr  <= row_base + HOR_A + ADDR_W'(x0);
                  end else begin
                     // Go straight to the next op, so only one LOAD cycle separates two rects.
                     wr_en <= 1'b0;
                     state <= fifo_empty ? IDLE : LOAD;
                  end
               end
               CLEAR: begin
                  if (wr_addr == LAST_A) begin
                     wr_en <= 1'b0;
                     state <= IDLE;
                  end else begin
                     wr_addr <= wr_addr + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rect_raster_engine.sv
// Scoreboard bench for rect_raster_engine on an 8x4 frame with a 4-entry op FIFO.
// Expected pixels are queued when an op is accepted and compared as the DUT writes them.
module tb_rect_raster_engine;
   import gpu2_pkg::*;

   localparam int         HOR = 8;
   localparam int         VER = 4;
   localparam logic [3:0] BG  = 4'h3;

   typedef struct { int addr; int data; } px_t;

   logic       clk = 1'b0, rst = 1'b0, ce = 1'b1, swap = 1'b0, op_valid = 1'b0;
   rect_op_t   op = '0;
   logic       op_ready, wr_en, busy;
   logic [4:0] wr_addr;
   logic [3:0] wr_data;

   px_t sb[$];
   int  n_chk = 0, n_pass = 0, cyc = 0, first_wr = -1, acc_cyc = 0;

   rect_raster_engine #(
      .HOR_ACTIVE_PIXELS(HOR), .VER_ACTIVE_PIXELS(VER), .COLOR_WIDTH(4),
      .OP_FIFO_DEPTH(4), .CLEAR_ON_SWAP(1'b1), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce), .swap(swap), .op(op), .op_valid(op_valid),
      .op_ready(op_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // The frame-buffer sink takes a pixel only when wr_en and ce are both high.
   always @(negedge clk) begin : mon
      px_t e;
      if (rst && ce && wr_en) begin
         if (first_wr < 0) first_wr = cyc;
         if (sb.size() == 0) chk("unexpected_wr", int'(wr_en), 0);
         else begin
            e = sb.pop_front();
            chk("wr_addr", int'(wr_addr), e.addr);
            chk("wr_data", int'(wr_data), e.data);
         end
      end
   end

   task automatic push_op(input int x, input int y, input int w, input int h, input int c);
      logic rdy;
      int   n;
      rdy = 1'b0;
      n   = 0;
      op.x     = OP_X_W'(x);
      op.y     = OP_Y_W'(y);
      op.w     = (OP_X_W+1)'(w);
      op.h     = (OP_Y_W+1)'(h);
      op.color = OP_C_W'(c);
      op_valid = 1'b1;
      while (!rdy && n < 200) begin
         @(negedge clk) rdy = op_ready;
         @(posedge clk) n++;
      end
      #1 op_valid = 1'b0;
      acc_cyc = cyc;
      chk("op_accept", int'(rdy), 1);
      if (rdy)
         for (int yy = y; yy < y + h && yy < VER; yy++)
            for (int xx = x; xx < x + w && xx < HOR; xx++)
               sb.push_back('{yy*HOR + xx, c});
   endtask

   task automatic push_clear();
      for (int a = 0; a < HOR*VER; a++) sb.push_back('{a, int'(BG)});
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((busy || sb.size() != 0) && n < 500) begin
         @(posedge clk) #1 n++;
      end
      chk(tag, int'(busy), 0);
      chk({tag, "_sb"}, sb.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int n;
      // Reset state, then ready one cycle after release
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      chk("rst_op_ready", int'(op_ready), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b1;
      @(posedge clk) #1;
      chk("ready_after_rst", int'(op_ready), 1);

      // 1: basic rect and first-write latency
      first_wr = -1;
      push_op(2, 1, 3, 2, 5);
      wait_idle("t1_idle");
      chk("t1_latency", first_wr - acc_cyc, 2);

      // 2: clipping and empty ops
      push_op(6, 3, 5, 5, 7);
      wait_idle("t2_clip");
      push_op(9, 0, 2, 2, 1);
      push_op(1, 1, 0, 3, 2);
      push_op(0, 5, 2, 2, 8);
      wait_idle("t2_empty");

      // 3: five ops back to back fill the FIFO
      push_op(0, 0, 8, 1, 1);
      push_op(0, 1, 4, 2, 2);
      push_op(5, 2, 3, 2, 3);
      push_op(2, 0, 2, 4, 4);
      push_op(7, 3, 1, 1, 6);
      chk("t3_full_ready", int'(op_ready), 0);
      wait_idle("t3_idle");

      // 4: swap mid-draw with a queued op -> clear only
      push_op(0, 0, 8, 4, 9);
      push_op(1, 1, 2, 2, 4);
      repeat (8) @(posedge clk);
      #1 swap = 1'b1;
      @(posedge clk);
      sb.delete();
      push_clear();
      #1 swap = 1'b0;
      chk("t4_clear_ready", int'(op_ready), 0);
      chk("t4_clear_busy", int'(busy), 1);
      wait_idle("t4_clear");
      chk("t4_ready_after", int'(op_ready), 1);

      // 4b: op offered in the swap cycle is discarded
      op = '0;
      op.w = 1;
      op.h = 1;
      op.color = 5;
      op_valid = 1'b1;
      swap = 1'b1;
      @(posedge clk);
      push_clear();
      #1 op_valid = 1'b0;
      swap = 1'b0;
      wait_idle("t4_swap_discard");

      // 5: ce toggling during a rect
      push_op(2, 1, 3, 2, 5);
      n = 0;
      while ((busy || sb.size() != 0) && n < 100) begin
         @(posedge clk) #1 ce = ~ce;
         n++;
      end
      ce = 1'b1;
      chk("t5_ce_sb", sb.size(), 0);
      chk("t5_ce_busy", int'(busy), 0);

      // 6: reset mid-clear
      swap = 1'b1;
      @(posedge clk);
      push_clear();
      #1 swap = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) #2 rst = 1'b0;
      sb.delete();
      #1;
      chk("t6_wr_en", int'(wr_en), 0);
      chk("t6_wr_addr", int'(wr_addr), 0);
      chk("t6_wr_data", int'(wr_data), 0);
      chk("t6_op_ready", int'(op_ready), 0);
      chk("t6_busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk) #1;
      chk("t6_ready_after", int'(op_ready), 1);
      chk("t6_busy_after", int'(busy), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("t6_no_stale_wr", int'(wr_en), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
